adder_share_arb: RTL
====================

Name: adder_share_arb

Overview:
- Time-shares one cla_adder instance between NREQ datapath requesters in the memory-based DCT8 core, e.g. butterfly stages and the partial-sum accumulator.
- Round-robin arbitration with per-requester valid/ready on the request side.
- One registered result with valid/ready and a requester tag on the response side.
- Throughput is one add per cycle when the response side is not stalled.

Parameters:
- NREQ, 4, number of requesters (>=1).
- WIDTH, 16, operand and sum width.
- IDW, $clog2(NREQ) (min 1), width of the requester tag; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing.
- req_cin  in  NREQ  carry-in per requester.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  WIDTH  registered sum.
- rsp_cout  out  1  registered carry-out.
- rsp_id  out  IDW  index of the requester that produced the result.

Behaviour:
- Reset (clk edge with rst=1):
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, round-robin pointer=0.
  - Any held result is discarded.
  - req_ready is 0 during the reset cycle.
- Accept condition: can_accept = !rsp_valid || rsp_ready. Same-cycle drain and refill is allowed.
- Arbitration (combinational):
  - Among req_valid bits, grant the first index at or after the pointer, wrapping modulo NREQ.
  - req_ready[g]=1 only if can_accept and a request exists. Otherwise req_ready=0.
  - req_ready never depends combinationally on its own req_valid bit beyond selection. No combinational path from rsp_ready to rsp_valid.
- Transfer: a request fires when req_valid[i] && req_ready[i]. At most one fires per cycle.
- Datapath: the granted requester's a/b/cin are muxed into cla_adder. On the firing edge:
  - {rsp_cout, rsp_sum} <= a+b+cin, full WIDTH+1 bits, no saturation, wrap modulo 2^WIDTH.
  - rsp_id <= g.
  - rsp_valid <= 1.
- Latency: result is visible exactly 1 cycle after the firing edge.
- Drain: if rsp_valid && rsp_ready and nothing fires, rsp_valid <= 0 next edge. rsp_sum, rsp_cout and rsp_id hold their last values.
- Stall: rsp_valid && !rsp_ready holds all rsp_* stable and forces req_ready=0.
- Pointer: on a fire, pointer <= (g+1) mod NREQ. With no fire, the pointer is unchanged.
  - A requester holding valid is served within NREQ fires (fairness bound).
- Requester protocol: once req_valid is asserted, operands and valid are held until ready. The arbiter does not check this.
- NREQ=1: the pointer is constant 0, rsp_id is constant 0, and req_ready[0]=can_accept && req_valid[0].
- Pointer wrap: index NREQ-1 wraps to 0. Non-power-of-two NREQ must wrap correctly (e.g. NREQ=3: 2 -> 0).
- rst has priority over all simultaneous events, including a fire in the same cycle.

Decomposition:
- Shared package dct_pkg holds:
  - ADD_WIDTH default (16).
  - The NREQ default.
  - A clog2-min-1 helper function for IDW.
- Sub-module rr_arbiter (NREQ): req, enable, pointer update on fire; outputs one-hot grant plus encoded index.
- cla_adder is instantiated unchanged as the shared datapath.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0. After release, the first grant goes to requester 0.
- Single add: req 2 with a=0x1234, b=0x0001, cin=1, rsp_ready=1 -> req_ready=4'b0100 same cycle. Next cycle rsp_valid=1, rsp_sum=0x1236, rsp_cout=0, rsp_id=2.
- Overflow: req 0 with a=0xFFFF, b=0x0001, cin=0 -> rsp_sum=0x0000, rsp_cout=1. Then a=0xFFFF, b=0xFFFF, cin=1 -> rsp_sum=0xFFFF, rsp_cout=1.
- Round-robin: all four valid continuously with rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1, one result per cycle. With only reqs 1 and 3 valid -> 1,3,1,3.
- Backpressure: rsp_ready=0 while rsp_valid=1 for 5 cycles -> req_ready=0, rsp_* stable. Raise rsp_ready -> a new grant in the same cycle and a new result on the next edge, with no bubble.
- Mid-operation reset: assert rst in the cycle a request fires with rsp_valid=1 -> next cycle rsp_valid=0, pointer=0, and the fired result is lost. Repeat the round-robin test with NREQ=3 to check wrap 2 -> 0.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared definitions for the memory-based DCT8 core datapath blocks.
package dct_pkg;

    localparam int ADD_WIDTH = 16;
    localparam int NREQ_DEF  = 4;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cla_adder.sv
// Generate/propagate carry adder used as the shared DCT adder datapath.
module cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Carry recurrence is written linearly; synthesis flattens it into lookahead logic.
    always_comb begin
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum  = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module rr_arbiter
    import dct_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IDW  = clog2_min1(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            fire
);

    logic [IDW-1:0] ptr;
    logic           found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                found                          = 1'b1;
                grant[(int'(ptr) + k) % NREQ]  = enable;
                idx                            = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign fire = enable && found;

    // Explicit wrap keeps non-power-of-two NREQ inside 0..NREQ-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (fire) begin
            ptr <= (idx == IDW'(NREQ - 1)) ? '0 : idx + IDW'(1);
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// Shares one cla_adder among NREQ requesters with a registered, tagged result.
module adder_share_arb
    import dct_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEF,
    parameter  int WIDTH = ADD_WIDTH,
    localparam int IDW   = clog2_min1(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id
);

    logic             can_accept;
    logic [IDW-1:0]   gidx;
    logic             fire;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             cin_sel;
    logic [WIDTH-1:0] sum_c;
    logic             cout_c;

    // Result slot frees up when empty or being drained this same cycle.
    assign can_accept = !rsp_valid || rsp_ready;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .enable (can_accept && !rst),
        .grant  (req_ready),
        .idx    (gidx),
        .fire   (fire)
    );

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        cin_sel = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == IDW'(i)) begin
                a_sel   = req_a[i*WIDTH +: WIDTH];
                b_sel   = req_b[i*WIDTH +: WIDTH];
                cin_sel = req_cin[i];
            end
        end
    end

    cla_adder #(.WIDTH(WIDTH)) u_add (
        .a    (a_sel),
        .b    (b_sel),
        .cin  (cin_sel),
        .sum  (sum_c),
        .cout (cout_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
        end else if (fire) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= sum_c;
            rsp_cout  <= cout_c;
            rsp_id    <= gidx;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
